// File: rtl/cu_pkg.sv
// Shared control-unit types: the instruction word handed to the decoder and
// the fetch-unit state encoding.
package cu_pkg;

    localparam int unsigned IR_WIDTH = 32;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  mode;
        logic [15:0] operand;
    } ir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ir_fifo.sv
// Synchronous FIFO holding fetched {pc, word} entries; the head is read
// combinationally and, when empty, keeps showing the last entry popped.
module ir_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_head_idx;

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != {CW{1'b0}});
    assign o_count = r_count;

    // Entry storage; a clear suppresses a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; clearing drops unread entries but leaves the
    // read pointer so the last popped entry is still the one shown when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= r_rd_ptr;
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head selection: live head when occupied, last popped slot when empty.
    always_comb begin
        w_head_idx = r_rd_ptr;
        if (r_count == {CW{1'b0}}) begin
            w_head_idx = r_rd_ptr - AW'(1);
        end else begin
            w_head_idx = r_rd_ptr;
        end
        o_head = r_mem[w_head_idx];
    end

endmodule

// File: rtl/ir_fetch.sv
// Instruction prefetch unit: single-outstanding word reads into a small FIFO,
// presented to the decoder as ir_t with valid/ready, redirected on flush.
module ir_fetch
    import cu_pkg::*;
#(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [31:0]           i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic                  o_ir_valid,
    output logic [31:0]           o_ir,
    output logic [ADDR_WIDTH-1:0] o_ir_pc,
    input  logic                  i_ir_ready,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_flush_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = IR_WIDTH + ADDR_WIDTH;

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_after;
    logic [EW-1:0]         w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ir_valid;
    ir_t                   w_head_ir;

    // Flush takes priority over both a returning word and a decoder pop.
    assign w_ir_valid    = (w_count != {CW{1'b0}});
    assign w_pop         = w_ir_valid && i_ir_ready && !i_flush;
    assign w_push        = (r_state == REQ) && i_mem_ack && !i_flush;
    assign w_count_after = w_count + CW'(1) - CW'(w_pop);

    assign w_head_ir  = ir_t'(w_head[IR_WIDTH-1:0]);
    assign o_ir       = w_head_ir;
    assign o_ir_pc    = w_head[EW-1:IR_WIDTH];
    assign o_ir_valid = w_ir_valid;
    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;

    ir_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (i_flush),
        .i_wdata ({r_pc, i_mem_rdata}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Fetch FSM with registered bus outputs; the address never moves while a
    // request is outstanding, so a flushed request finishes in SQUASH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_flush) begin
                        r_pc <= i_flush_pc;
                    end else if (w_count != CW'(DEPTH)) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                    end
                end
                REQ: begin
                    if (i_flush) begin
                        r_pc <= i_flush_pc;
                        if (i_mem_ack) begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_state <= SQUASH;
                        end
                    end else if (i_mem_ack) begin
                        r_pc       <= r_pc + ADDR_WIDTH'(1);
                        r_mem_addr <= r_pc + ADDR_WIDTH'(1);
                        if (w_count_after < CW'(DEPTH)) begin
                            r_state <= REQ;
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                SQUASH: begin
                    if (i_flush) begin
                        r_pc <= i_flush_pc;
                    end
                    if (i_mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
